// File: rtl/pdm_cic_decimator.sv
// Second-order CIC decimator: 1-bit PDM in, unsigned PCM out at clk/R.
// One-deep valid/ready output register with a sticky overrun flag.
module pdm_cic_decimator #(
  parameter int LOG2_R = 4,
  localparam int OUT_W = 2*LOG2_R+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pdm_in,
  input  logic             pcm_ready,
  input  logic             clear_ovf,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  output logic             overrun
);

  logic [OUT_W-1:0]  i1, i2, d1, c1, e1;
  logic [OUT_W-1:0]  result;
  logic [LOG2_R-1:0] cnt;
  logic              s1;
  logic              ds;

  assign ds     = en && (cnt == {LOG2_R{1'b1}});
  assign result = c1 - e1;

  // Integrators and decimation counter; en=0 freezes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1  <= '0;
      i2  <= '0;
      cnt <= '0;
    end else if (en) begin
      i1  <= i1 + OUT_W'(pdm_in);
      i2  <= i2 + i1;
      cnt <= cnt + LOG2_R'(1);
    end
  end

  // Comb section; the strobe pipeline runs every cycle independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      c1 <= '0;
      e1 <= '0;
      s1 <= 1'b0;
    end else begin
      s1 <= ds;
      if (ds) begin
        c1 <= i2 - d1;
        d1 <= i2;
      end
      if (s1) begin
        e1 <= c1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (s1 && (!pcm_valid || pcm_ready)) begin
        pcm_data  <= result;
        pcm_valid <= 1'b1;
      end else if (!s1 && pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
      // A drop on the same edge as clear_ovf must leave the flag set.
      if (clear_ovf) begin
        overrun <= 1'b0;
      end
      if (s1 && pcm_valid && !pcm_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: closed-form CIC2 model over the consumed bit
// history, per-cycle output compare, and literal checks on known sequences.
module tb_pdm_cic_decimator;
  localparam int LOG2_R = 4;
  localparam int R      = 1 << LOG2_R;
  localparam int OUT_W  = 2*LOG2_R+1;
  localparam int MASK   = (1 << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             pdm_in = 1'b0;
  logic             pcm_ready = 1'b1;
  logic             clear_ovf = 1'b0;
  logic [OUT_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             overrun;

  pdm_cic_decimator #(.LOG2_R(LOG2_R)) dut (
    .clk(clk), .rst(rst), .en(en), .pdm_in(pdm_in),
    .pcm_ready(pcm_ready), .clear_ovf(clear_ovf),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: second difference (spacing R) of the double running sum of
  // consumed bits, sampled after every R-th consumed bit.
  bit hist[$];
  int m_k, m_c1prev, m_pend;
  bit m_arrive;
  bit ev, eo;
  int ed;
  bit m_new, m_set;
  int m_nv, m_c1;

  function automatic longint dsum(input int n);
    longint s = 0;
    for (int j = 0; j <= n - 2; j++)
      if (hist[j]) s += longint'(n - 1 - j);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_k = 0; m_c1prev = 0; m_pend = 0; m_arrive = 0;
      ev = 0; ed = 0; eo = 0;
    end else begin
      m_new = m_arrive;
      m_nv  = m_pend;
      m_arrive = 0;
      if (en) begin
        hist.push_back(pdm_in);
        if (hist.size() % R == 0) begin
          m_k++;
          m_c1 = int'(dsum(m_k*R - 1) - dsum((m_k-1)*R - 1));
          m_pend = (m_c1 - m_c1prev) & MASK;
          m_c1prev = m_c1;
          m_arrive = 1;
        end
      end
      m_set = m_new && ev && !pcm_ready;
      if (m_new && (!ev || pcm_ready)) begin
        ed = m_nv;
        ev = 1;
      end else if (!m_new && ev && pcm_ready) begin
        ev = 0;
      end
      if (clear_ovf) eo = 0;
      if (m_set) eo = 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int got_v[$];
  int got_c[$];

  always @(negedge clk) begin
    check("valid", int'(pcm_valid), int'(ev));
    check("overrun", int'(overrun), int'(eo));
    if (ev) check("data", int'(pcm_data), ed);
    if (pcm_valid && pcm_ready) begin
      got_v.push_back(int'(pcm_data));
      got_c.push_back(cyc);
    end
  end

  // Stimulus: mode 0 const 0, 1 const 1, 2 alternating 1/0, 3 NCO sigma-delta.
  int       mode;
  bit       tog;
  int       ph;
  bit [7:0] nco_phase, nco_sd;

  task automatic step();
    bit [8:0] sum;
    @(negedge clk);
    #1;
    en = tog ? ~en : 1'b1;
    if (en) begin
      case (mode)
        0: pdm_in = 1'b0;
        1: pdm_in = 1'b1;
        2: pdm_in = (ph % 2 == 0);
        default: begin
          nco_phase = nco_phase + 8'd64;
          sum = {1'b0, nco_sd} + {1'b0, nco_phase};
          nco_sd = sum[7:0];
          pdm_in = sum[8];
        end
      endcase
      ph++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int md, input bit tg);
    rst = 1'b1; en = 1'b0; pdm_in = 1'b0; clear_ovf = 1'b0;
    mode = md; tog = tg; ph = 0; nco_phase = 0; nco_sd = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    got_v.delete();
    got_c.delete();
  endtask

  task automatic check_seq(input string name, input int v0, input int v1,
                           input int vss, input int period, input int min_n);
    check({name, "_count_ok"}, int'(got_v.size() >= min_n), 1);
    if (got_v.size() >= min_n) begin
      check({name, "_s1"}, got_v[0], v0);
      check({name, "_s2"}, got_v[1], v1);
      for (int i = 2; i < got_v.size(); i++) check({name, "_ss"}, got_v[i], vss);
      for (int i = 1; i < got_v.size(); i++)
        check({name, "_period"}, got_c[i] - got_c[i-1], period);
    end
  endtask

  int c0;

  initial begin
    pcm_ready = 1'b1;
    mode = 0; tog = 0; ph = 0;

    do_reset(1, 0);
    run(100);
    check_seq("ones", 105, 255, 256, 16, 5);
    check("ones_ovf", int'(overrun), 0);

    do_reset(2, 0);
    run(100);
    check_seq("alt", 56, 128, 128, 16, 5);

    do_reset(0, 0);
    run(100);
    check_seq("zeros", 0, 0, 0, 16, 5);

    do_reset(3, 0);
    run(320);
    check("nco_count_ok", int'(got_v.size() >= 18), 1);

    do_reset(1, 0);
    pcm_ready = 1'b0;
    run(40);
    check("hold_data", int'(pcm_data), 105);
    check("hold_valid", int'(pcm_valid), 1);
    check("hold_ovf", int'(overrun), 1);
    for (int i = 0; i < 40 && !m_arrive; i++) step();
    check("arrive_seen", int'(m_arrive), 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("ovf_set_wins", int'(overrun), 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("ovf_cleared", int'(overrun), 0);
    pcm_ready = 1'b1;
    run(4);

    do_reset(1, 1);
    run(32*6 + 10);
    check_seq("entog", 105, 255, 256, 32, 5);

    do_reset(1, 0);
    pcm_ready = 1'b0;
    run(40);
    for (int i = 0; i < 40 && !m_arrive; i++) step();
    check("rst_arrive_seen", int'(m_arrive), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_valid", int'(pcm_valid), 0);
    check("rst_data", int'(pcm_data), 0);
    check("rst_ovf", int'(overrun), 0);
    pcm_ready = 1'b1;
    #4 rst = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 40 && !pcm_valid; i++) step();
    check("rst_latency", cyc - c0, 17);
    check("rst_first", int'(pcm_data), 105);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
